// File: rtl/uart_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_ctrl
// Brief    : Assembles UART receive bytes into checksummed write frames
//            (HEADER, ADDR, LEN, payload, CSUM). The payload is buffered and
//            replayed to the register bank only after the checksum matches.
// Revision : 1.0 - initial release
// ============================================================================
module uart_frame_ctrl #(
  parameter logic [7:0] HEADER      = 8'hA5,
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 104_170
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic [7:0] rx_dat,
  input  logic       data_rdy,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       frame_done,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int         IW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int         TW        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_LEN    = 3'd2,
    S_DATA   = 3'd3,
    S_CSUM   = 3'd4,
    S_COMMIT = 3'd5
  } state_t;

  state_t        state, state_n;
  logic          data_rdy_d;
  logic          rx_valid;
  logic [7:0]    base, len, idx, csum;
  logic [TW-1:0] tcnt;
  logic          last_d;
  logic [7:0]    buffer [0:(1<<IW)-1];

  // control decoded from the state machine
  logic       take_addr, take_len, take_data;
  logic       csum_clr, idx_clr;
  logic       wr_fire, last_wr;
  logic       err_fire;
  logic [1:0] err_n;
  logic       active, timeout, tcnt_clr;

  // Rising edge of data_rdy: a held-high level counts as one byte.
  assign rx_valid = data_rdy & ~data_rdy_d;
  assign busy     = (state != S_IDLE);
  assign active   = (state == S_ADDR) || (state == S_LEN) ||
                    (state == S_DATA) || (state == S_CSUM);
  assign timeout  = active && (tcnt == TO_LAST);
  // The inter-byte timer restarts on every accepted byte and on every state change.
  assign tcnt_clr = rx_valid || (state_n != state) || !active;

  // State register.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next-state and per-cycle control decode.
  always_comb begin
    state_n   = state;
    take_addr = 1'b0;
    take_len  = 1'b0;
    take_data = 1'b0;
    csum_clr  = 1'b0;
    idx_clr   = 1'b0;
    wr_fire   = 1'b0;
    last_wr   = 1'b0;
    err_fire  = 1'b0;
    err_n     = 2'b00;
    case (state)
      S_IDLE: begin
        if (rx_valid && (rx_dat == HEADER)) begin
          state_n  = S_ADDR;
          csum_clr = 1'b1;
        end
      end
      S_ADDR: begin
        if (rx_valid) begin
          take_addr = 1'b1;
          state_n   = S_LEN;
        end
      end
      S_LEN: begin
        if (rx_valid) begin
          if ((rx_dat == 8'd0) || (rx_dat > MAX_LEN_B)) begin
            state_n  = S_IDLE;
            err_fire = 1'b1;
            err_n    = 2'b01;
          end else begin
            take_len = 1'b1;
            idx_clr  = 1'b1;
            state_n  = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          take_data = 1'b1;
          if ((idx + 8'd1) == len) state_n = S_CSUM;
        end
      end
      S_CSUM: begin
        if (rx_valid) begin
          if (rx_dat == csum) begin
            state_n = S_COMMIT;
            idx_clr = 1'b1;
          end else begin
            state_n  = S_IDLE;
            err_fire = 1'b1;
            err_n    = 2'b10;
          end
        end
      end
      S_COMMIT: begin
        // Incoming bytes are ignored while the buffer is replayed.
        wr_fire = 1'b1;
        if ((idx + 8'd1) == len) begin
          last_wr = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
    // A byte arriving in the same cycle as the timeout takes precedence.
    if (timeout && !rx_valid) begin
      state_n  = S_IDLE;
      err_fire = 1'b1;
      err_n    = 2'b11;
    end
  end

  // Datapath registers, timer and registered output strobes.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      data_rdy_d <= 1'b0;
      base       <= 8'd0;
      len        <= 8'd0;
      idx        <= 8'd0;
      csum       <= 8'd0;
      tcnt       <= '0;
      last_d     <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= 8'd0;
      wr_data    <= 8'd0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= 2'b00;
    end else begin
      data_rdy_d <= data_rdy;
      if (take_addr) base <= rx_dat;
      if (take_len)  len  <= rx_dat;
      if (csum_clr)
        csum <= 8'd0;
      else if (take_addr || take_len || take_data)
        csum <= csum ^ rx_dat;
      if (idx_clr)
        idx <= 8'd0;
      else if (take_data || wr_fire)
        idx <= idx + 8'd1;
      tcnt <= tcnt_clr ? '0 : tcnt + TW'(1);
      wr_en <= wr_fire;
      if (wr_fire) begin
        wr_addr <= base + idx;
        wr_data <= buffer[idx[IW-1:0]];
      end
      // frame_done lands one cycle after the final wr_en.
      last_d     <= last_wr;
      frame_done <= last_d;
      frame_err  <= err_fire;
      if (err_fire) err_code <= err_n;
    end
  end

  // Payload buffer; contents are don't-care out of reset.
  always_ff @(posedge clk_sys) begin
    if (take_data) buffer[idx[IW-1:0]] <= rx_dat;
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_uart_frame_ctrl
// Brief    : Directed self-checking bench for uart_frame_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_frame_ctrl;

  localparam int MAXL = 16;
  localparam int TO   = 200;
  localparam int GAP  = 20;

  logic       clk_sys = 1'b0;
  logic       rst_n   = 1'b0;
  logic [7:0] rx_dat  = 8'h00;
  logic       data_rdy = 1'b0;
  logic       wr_en, frame_done, frame_err, busy;
  logic [7:0] wr_addr, wr_data;
  logic [1:0] err_code;

  uart_frame_ctrl #(
    .HEADER     (8'hA5),
    .MAX_LEN    (MAXL),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk_sys   (clk_sys),
    .rst_n     (rst_n),
    .rx_dat    (rx_dat),
    .data_rdy  (data_rdy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .frame_done(frame_done),
    .frame_err (frame_err),
    .err_code  (err_code),
    .busy      (busy)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  // Output log, sampled on the falling edge.
  logic [15:0] wrq[$];
  int          wrc[$];
  int          n_done = 0, done_cyc = 0, n_err = 0, err_cyc = 0, n_both = 0;
  logic [1:0]  last_code = 2'b00;

  always @(negedge clk_sys) begin
    if (wr_en) begin
      wrq.push_back({wr_addr, wr_data});
      wrc.push_back(cyc);
    end
    if (frame_done) begin
      n_done   <= n_done + 1;
      done_cyc <= cyc;
    end
    if (frame_err) begin
      n_err     <= n_err + 1;
      err_cyc   <= cyc;
      last_code <= err_code;
    end
    if (frame_err && frame_done) n_both <= n_both + 1;
  end

  int vectors = 0, miscompares = 0;
  int mark_wr = 0, mark_done = 0, mark_err = 0, rise_cyc = 0, t0 = 0;
  logic [7:0]  fq[$];
  logic [15:0] expq[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic mark();
    mark_wr   = wrq.size();
    mark_done = n_done;
    mark_err  = n_err;
  endtask

  task automatic send(input logic [7:0] b, input int hold);
    @(negedge clk_sys);
    rx_dat   = b;
    data_rdy = 1'b1;
    rise_cyc = cyc;
    repeat (hold) @(negedge clk_sys);
    data_rdy = 1'b0;
    repeat (GAP) @(negedge clk_sys);
  endtask

  task automatic send_frame(input int hold);
    foreach (fq[i]) send(fq[i], hold);
  endtask

  task automatic check_writes(input string tag);
    int n;
    n = wrq.size() - mark_wr;
    check({tag, "_nwr"}, n, expq.size());
    for (int i = 0; i < expq.size(); i++)
      if (i < n) check($sformatf("%s_w%0d", tag, i), wrq[mark_wr + i], expq[i]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk_sys);
    check("rst_outs", {wr_en, frame_done, frame_err, busy, wr_addr, wr_data, err_code}, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    // Good frame: csum 10^03^11^22^33 = 13
    mark();
    fq = {8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h13};
    send_frame(1);
    expq = {16'h1011, 16'h1122, 16'h1233};
    check_writes("good");
    if (wrq.size() >= mark_wr + 3) begin
      check("good_lat", wrc[mark_wr] - rise_cyc, 2);
      check("good_consec", wrc[mark_wr + 2] - wrc[mark_wr], 2);
      check("good_done_cyc", done_cyc - wrc[mark_wr + 2], 1);
    end
    check("good_done", n_done - mark_done, 1);
    check("good_noerr", n_err - mark_err, 0);

    // Bad checksum, then a good frame
    mark();
    fq = {8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h14};
    send_frame(1);
    expq = {};
    check_writes("badcs");
    check("badcs_err", n_err - mark_err, 1);
    check("badcs_code", last_code, 2'b10);
    check("badcs_done", n_done - mark_done, 0);
    mark();
    fq = {8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h13};
    send_frame(1);
    expq = {16'h1011, 16'h1122, 16'h1233};
    check_writes("regood");

    // Illegal LEN: 0 and MAX_LEN+1
    mark();
    fq = {8'hA5, 8'h20, 8'h00};
    send_frame(1);
    check("len0_err", n_err - mark_err, 1);
    check("len0_code", last_code, 2'b01);
    check("len0_busy", busy, 1'b0);
    mark();
    fq = {8'hA5, 8'h20, 8'h11};
    send_frame(1);
    check("len17_err", n_err - mark_err, 1);
    check("len17_code", last_code, 2'b01);
    check("len17_busy", busy, 1'b0);

    // LEN == MAX_LEN: payload 00..0F xors to 0, csum = 50^10 = 40
    mark();
    fq = {8'hA5, 8'h50, 8'h10};
    for (int i = 0; i < 16; i++) fq.push_back(8'(i));
    fq.push_back(8'h40);
    send_frame(1);
    expq = {};
    for (int i = 0; i < 16; i++) expq.push_back({8'(8'h50 + i), 8'(i)});
    check_writes("maxlen");
    check("maxlen_done", n_done - mark_done, 1);

    // Address near top: FE^02^AA^BB = ED
    mark();
    fq = {8'hA5, 8'hFE, 8'h02, 8'hAA, 8'hBB, 8'hED};
    send_frame(1);
    expq = {16'hFEAA, 16'hFFBB};
    check_writes("top");
    // Address wrap: FF^02^11^22 = CE
    mark();
    fq = {8'hA5, 8'hFF, 8'h02, 8'h11, 8'h22, 8'hCE};
    send_frame(1);
    expq = {16'hFF11, 16'h0022};
    check_writes("wrap");

    // Timeout mid-payload
    mark();
    fq = {8'hA5, 8'h10, 8'h03, 8'h11};
    send_frame(1);
    t0 = rise_cyc;
    for (int i = 0; i < 3 * TO && n_err == mark_err; i++) @(negedge clk_sys);
    check("to_seen", n_err - mark_err, 1);
    check("to_not_early", (err_cyc - t0) >= TO, 1'b1);
    check("to_not_late", (err_cyc - t0) <= TO + 2, 1'b1);
    check("to_code", last_code, 2'b11);
    check("to_busy", busy, 1'b0);
    expq = {};
    check_writes("to");
    mark();
    send(8'h55, 1);
    check("post_to_55_busy", busy, 1'b0);
    check("post_to_55_err", n_err - mark_err, 0);
    fq = {8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h13};
    send_frame(1);
    expq = {16'h1011, 16'h1122, 16'h1233};
    check_writes("post_to");

    // Noise before header, data_rdy held 3 cycles per byte: 30^02^01^02 = 31
    mark();
    fq = {8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h30, 8'h02, 8'h01, 8'h02, 8'h31};
    send_frame(3);
    expq = {16'h3001, 16'h3102};
    check_writes("hold3");
    check("hold3_done", n_done - mark_done, 1);
    check("hold3_err", n_err - mark_err, 0);

    // Reset in the middle of DATA
    mark();
    fq = {8'hA5, 8'h40, 8'h04, 8'h01, 8'h02};
    send_frame(1);
    check("mid_busy", busy, 1'b1);
    @(negedge clk_sys);
    rst_n = 1'b0;
    @(negedge clk_sys);
    check("mid_rst_outs", {wr_en, frame_done, frame_err, busy, wr_addr, wr_data, err_code}, 32'h0);
    rst_n = 1'b1;
    repeat (30) @(negedge clk_sys);
    expq = {};
    check_writes("mid_rst");
    check("mid_rst_done", n_done - mark_done, 0);
    check("mid_rst_err", n_err - mark_err, 0);

    check("no_overlap", n_both, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
